// File: rtl/audio_pkg.sv
// Shared constants and types for the audio sample pacer.
package audio_pkg;

    localparam int unsigned DEFAULT_DIV = 1227;
    localparam int unsigned MIN_DIV     = 2;
    localparam int unsigned SPEED_STEP  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: clamps the requested end-count and emits a tick every eff_end+1 cycles.
module sample_tick_gen
    import audio_pkg::*;
#(
    parameter int unsigned DIV_W   = 32,
    parameter int unsigned MIN_DIV = audio_pkg::MIN_DIV
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] clk_div_end,
    output logic             tick
);

    localparam logic [DIV_W-1:0] MIN_END = DIV_W'(MIN_DIV);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic [DIV_W-1:0] eff_end;

    // Compare with >= so a lowered end-count below the running count ticks at once.
    assign eff_end = (clk_div_end < MIN_END) ? MIN_END : clk_div_end;
    assign tick    = enable && (div_cnt_q >= eff_end);

    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (!enable || tick) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/audio_sample_pacer.sv
// Paces 16-bit samples out of prefetched 32-bit words, low half first.
// state | meaning
// IDLE  | no request outstanding
// WAIT  | word_req high, waiting for word_ack
module audio_sample_pacer #(
    parameter int unsigned DIV_W   = 32,
    parameter int unsigned MIN_DIV = audio_pkg::MIN_DIV
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] clk_div_end,
    input  logic             enable,
    output logic             word_req,
    input  logic             word_ack,
    input  logic [31:0]      word_data,
    output logic [15:0]      sample_out,
    output logic             sample_valid,
    output logic             underrun
);
    import audio_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  cur_q, cur_d, nxt_q, nxt_d;
    logic         cur_v_q, cur_v_d, nxt_v_q, nxt_v_d, half_q, half_d;
    logic [15:0]  sample_q, sample_d;
    logic         valid_q, valid_d, underrun_q, underrun_d;
    logic         tick;
    logic         ack_take;

    sample_tick_gen #(
        .DIV_W   (DIV_W),
        .MIN_DIV (MIN_DIV)
    ) u_tick (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .clk_div_end (clk_div_end),
        .tick        (tick)
    );

    assign ack_take = word_ack && (state_q == WAIT);

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        cur_v_d    = cur_v_q;
        nxt_d      = nxt_q;
        nxt_v_d    = nxt_v_q;
        half_d     = half_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        underrun_d = 1'b0;

        if (tick) begin
            if (cur_v_q) begin
                sample_d = half_q ? cur_q[31:16] : cur_q[15:0];
                valid_d  = 1'b1;
                half_d   = ~half_q;
                if (half_q) begin
                    if (nxt_v_q) begin
                        cur_d   = nxt_q;
                        nxt_v_d = 1'b0;
                    end else begin
                        cur_v_d = 1'b0;
                    end
                end
            end else begin
                underrun_d = 1'b1;
            end
        end

        // The tick above is applied first, so an ack landing on the emptying tick refills cur.
        if (ack_take) begin
            if (!cur_v_d) begin
                cur_d   = word_data;
                cur_v_d = 1'b1;
                half_d  = 1'b0;
            end else begin
                nxt_d   = word_data;
                nxt_v_d = 1'b1;
            end
        end

        case (state_q)
            IDLE:    if (enable && !nxt_v_q) state_d = WAIT;
            WAIT:    if (word_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            cur_v_q    <= 1'b0;
            nxt_q      <= '0;
            nxt_v_q    <= 1'b0;
            half_q     <= 1'b0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            cur_v_q    <= cur_v_d;
            nxt_q      <= nxt_d;
            nxt_v_q    <= nxt_v_d;
            half_q     <= half_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            underrun_q <= underrun_d;
        end
    end

    assign word_req     = (state_q == WAIT);
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Directed bench for audio_sample_pacer: rate, clamp, speed change, underrun, prefetch, reset.
module tb_audio_sample_pacer;
    import audio_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [31:0] clk_div_end;
    logic        enable;
    logic        word_req;
    logic        word_ack;
    logic [31:0] word_data;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        underrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    audio_sample_pacer #(.DIV_W(32), .MIN_DIV(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clk_div_end  (clk_div_end),
        .enable       (enable),
        .word_req     (word_req),
        .word_ack     (word_ack),
        .word_data    (word_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for the next sample_valid or underrun pulse; t = -1 on timeout.
    task automatic next_evt(input int budget, output int t, output bit v, output bit u,
                            output logic [15:0] s);
        t = -1; v = 1'b0; u = 1'b0; s = 16'hxxxx;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sample_valid || underrun) begin
                t = cyc; v = sample_valid; u = underrun; s = sample_out;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        enable   = 1'b0;
        word_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2;
        bit v, u, req_seen;
        int nv;
        logic [15:0] s;
        logic [15:0] got0, got1;

        reset_n = 1'b0; enable = 1'b0; word_ack = 1'b0; word_data = '0;
        clk_div_end = DEFAULT_DIV;
        repeat (2) @(negedge clk);
        chk("rst_req", word_req, 0);
        chk("rst_sample", sample_out, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_underrun", underrun, 0);
        reset_n = 1'b1;

        // Rate: end-count 3, ack on the request's second cycle.
        clk_div_end = 3;
        @(negedge clk);
        enable = 1'b1;
        chk("req_before_edge", word_req, 0);
        @(negedge clk);
        chk("req_first_edge", word_req, 1);
        @(negedge clk);
        word_ack = 1'b1; word_data = 32'hBBBB_AAAA;
        @(negedge clk);
        word_ack = 1'b0;
        next_evt(20, t1, v, u, s);
        chk("rate_v0", v, 1); chk("rate_s0", s, 16'hAAAA); chk("rate_u0", u, 0);
        next_evt(20, t2, v, u, s);
        chk("rate_v1", v, 1); chk("rate_s1", s, 16'hBBBB); chk("rate_per", t2 - t1, 4);
        chk("rate_u1", u, 0);
        next_evt(20, t1, v, u, s);
        chk("rate_empty_u", u, 1); chk("rate_empty_v", v, 0);
        chk("rate_empty_hold", s, 16'hBBBB); chk("rate_empty_per", t1 - t2, 4);

        // Underrun with ack withheld, then recovery.
        do_reset();
        clk_div_end = 3; enable = 1'b1;
        next_evt(20, t1, v, u, s);
        chk("und_u0", u, 1); chk("und_v0", v, 0); chk("und_s0", s, 0);
        next_evt(20, t2, v, u, s);
        chk("und_u1", u, 1); chk("und_per", t2 - t1, 4); chk("und_s1", s, 0);
        chk("und_req", word_req, 1);
        word_ack = 1'b1; word_data = 32'h2222_1111;
        @(negedge clk);
        word_ack = 1'b0;
        next_evt(20, t1, v, u, s);
        chk("und_rec_v0", v, 1); chk("und_rec_s0", s, 16'h1111); chk("und_rec_per", t1 - t2, 4);
        next_evt(20, t2, v, u, s);
        chk("und_rec_v1", v, 1); chk("und_rec_s1", s, 16'h2222); chk("und_rec_per1", t2 - t1, 4);

        // Clamp: end-count 0 and 1 both give a 3-cycle period.
        do_reset();
        clk_div_end = 0; enable = 1'b1; t0 = cyc;
        next_evt(20, t1, v, u, s);
        chk("clamp_first", t1 - t0, 3); chk("clamp_u", u, 1);
        next_evt(20, t2, v, u, s);
        chk("clamp_per0", t2 - t1, 3);
        clk_div_end = 1;
        next_evt(20, t1, v, u, s);
        chk("clamp_per1", t1 - t2, 3);

        // Speed change: 100 dropped to 20 while the count is 50.
        do_reset();
        clk_div_end = 100; enable = 1'b1;
        repeat (50) @(negedge clk);
        chk("speed_no_early", underrun, 0);
        clk_div_end = 20; t0 = cyc;
        next_evt(5, t1, v, u, s);
        chk("speed_next", t1 - t0, 1); chk("speed_u", u, 1);
        next_evt(40, t2, v, u, s);
        chk("speed_per", t2 - t1, 21);

        // Prefetch: two words buffered, no request until the first is consumed.
        do_reset();
        clk_div_end = 7; enable = 1'b1;
        @(negedge clk);
        chk("pf_req0", word_req, 1);
        word_ack = 1'b1; word_data = 32'h1234_5678;
        @(negedge clk);
        word_ack = 1'b0;
        chk("pf_req_drop", word_req, 0);
        @(negedge clk);
        chk("pf_req1", word_req, 1);
        word_ack = 1'b1; word_data = 32'h9ABC_DEF0;
        @(negedge clk);
        word_ack = 1'b0;
        req_seen = 1'b0; nv = 0; got0 = '0; got1 = '0;
        for (int i = 0; i < 40 && nv < 2; i++) begin
            @(negedge clk);
            if (word_req) req_seen = 1'b1;
            if (sample_valid) begin
                if (nv == 0) got0 = sample_out; else got1 = sample_out;
                nv++;
            end
        end
        chk("pf_req_held_low", req_seen, 0);
        chk("pf_count", nv, 2);
        chk("pf_w0_lo", got0, 16'h5678);
        chk("pf_w0_hi", got1, 16'h1234);
        @(negedge clk);
        chk("pf_req_after", word_req, 1);
        next_evt(20, t1, v, u, s);
        chk("pf_w1_lo", s, 16'hDEF0); chk("pf_w1_lo_v", v, 1);
        next_evt(20, t2, v, u, s);
        chk("pf_w1_hi", s, 16'h9ABC); chk("pf_w1_per", t2 - t1, 8);

        // Ack coincident with the tick that empties cur.
        do_reset();
        clk_div_end = 3; enable = 1'b1;
        @(negedge clk);
        word_ack = 1'b1; word_data = 32'h4444_3333;
        @(negedge clk);
        word_ack = 1'b0;
        next_evt(20, t1, v, u, s);
        chk("cc_s0", s, 16'h3333);
        repeat (3) @(negedge clk);
        chk("cc_req", word_req, 1);
        word_ack = 1'b1; word_data = 32'h6666_5555;
        @(negedge clk);
        word_ack = 1'b0;
        t0 = cyc;
        chk("cc_tick_v", sample_valid, 1); chk("cc_tick_s", sample_out, 16'h4444);
        next_evt(20, t2, v, u, s);
        chk("cc_new_v", v, 1); chk("cc_new_u", u, 0); chk("cc_new_s", s, 16'h5555);
        chk("cc_new_per", t2 - t0, 4);
        next_evt(20, t1, v, u, s);
        chk("cc_new_hi", s, 16'h6666);

        // Reset mid-handshake, then a late ack.
        do_reset();
        clk_div_end = 3; enable = 1'b1;
        @(negedge clk);
        word_ack = 1'b1; word_data = 32'h7777_8888;
        @(negedge clk);
        word_ack = 1'b0;
        next_evt(20, t1, v, u, s);
        chk("mr_pre_s", s, 16'h8888);
        chk("mr_pre_req", word_req, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_req", word_req, 0);
        chk("mr_sample", sample_out, 0);
        chk("mr_valid", sample_valid, 0);
        chk("mr_underrun", underrun, 0);
        @(negedge clk);
        enable = 1'b0; word_ack = 1'b1; word_data = 32'hDEAD_BEEF;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        word_ack = 1'b0;
        chk("late_ack_req", word_req, 0);
        next_evt(10, t1, v, u, s);
        chk("dis_no_v", v, 0); chk("dis_no_u", u, 0);
        enable = 1'b1;
        next_evt(20, t1, v, u, s);
        chk("late_ack_u", u, 1); chk("late_ack_v", v, 0); chk("late_ack_s", s, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_sample_pacer.md
# audio_sample_pacer

Consumes the divider end-count from the audio speed controller and paces 16-bit audio samples to the audio output path at the programmed rate. Fetches 32-bit packed sample words from the flash reader over a req/ack handshake, prefetching one word so that playback does not stall. Each 32-bit word is emitted as two 16-bit samples, low half first.

## Interface
Parameters:
- `DIV_W`, 32: width of the divider end-count.
- `MIN_DIV`, 2: floor applied to the effective end-count.

Ports:
- `clk`, in, 1: single system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `clk_div_end`, in, DIV_W: divider end-count from the speed controller. Sampled every cycle. Default setting is 1227.
- `enable`, in, 1: playback enable.
- `word_req`, out, 1: request for the next 32-bit sample word.
- `word_ack`, in, 1: one-cycle pulse. `word_data` is valid in the same cycle.
- `word_data`, in, 32: packed samples; [15:0] is the first sample, [31:16] is the second.
- `sample_out`, out, 16: current sample. Held between ticks.
- `sample_valid`, out, 1: one-cycle pulse when `sample_out` updates.
- `underrun`, out, 1: one-cycle pulse when a tick occurs with no buffered data.

## Operation
- Effective end: `eff_end = max(clk_div_end, MIN_DIV)`. The comparison is unsigned, DIV_W bits wide.
- Divider counter `div_cnt`:
  - Counts 0 to `eff_end`.
  - An internal tick fires when `div_cnt >= eff_end`; `div_cnt` then wraps to 0.
  - Tick period is `eff_end+1` cycles.
  - If `clk_div_end` drops below the current count, the tick fires on the next cycle.
- `enable` low:
  - `div_cnt` is held at 0 and no ticks fire.
  - No new request is raised.
  - An outstanding request stays high until acked, and its data is stored.
- Buffer: the current word register `cur` (with `cur_v` and half-select `half`) and the prefetch register `nxt` (with `nxt_v`).
- Fetch FSM has two states, IDLE and WAIT:
  - IDLE to WAIT when `enable && !nxt_v`. `word_req` goes high.
  - WAIT to IDLE on `word_ack`. `word_req` is registered and is low the cycle after the ack.
  - The acked word loads `cur` if `cur_v` is 0 after this cycle's tick processing; otherwise it loads `nxt`.
  - `word_ack` while `word_req` is low is ignored.
- Tick with `cur_v`:
  - `sample_out` takes `half ? cur[31:16] : cur[15:0]` and `sample_valid` pulses.
  - If `half` was 0, it flips to 1.
  - If `half` was 1, then `half` goes to 0, and `cur` takes `nxt` if `nxt_v` (clearing `nxt_v`); otherwise `cur_v` clears.
- Tick without `cur_v`: `underrun` pulses, `sample_out` holds, and `sample_valid` stays 0.
- Ack and tick in the same cycle: the tick consumes the old state first. If that empties `cur`, the acked word goes to `cur`; otherwise it goes to `nxt`. No word is lost or duplicated.

## Timing
- Reset values: `word_req`=0, `sample_out`=0, `sample_valid`=0, `underrun`=0, `div_cnt`=0, `cur_v`=`nxt_v`=0, `half`=0, FSM=IDLE.
- All outputs are registered.
- `sample_valid` and `underrun` appear 1 cycle after the tick condition (`div_cnt >= eff_end`).
- After reset release with `enable`=1, `word_req` rises on the first clock edge.
- Reset asserted mid-handshake clears `word_req` immediately (asynchronously). A late `word_ack` arriving after reset is ignored.
- A change on `clk_div_end` takes effect on the same cycle's comparison. There is no resynchronisation, because the speed controller is on the same clock.

## Structure
- Shared package `audio_pkg` holds:
  - `DEFAULT_DIV` (1227), `MIN_DIV`, and the speed step of 16.
  - The fetch-state enum `fetch_state_t` {IDLE, WAIT}.
- Sub-module `sample_tick_gen` contains the divider counter, the clamp, and tick generation.
- The top level contains the buffer, the half-select and the fetch FSM.

## Test plan
- Rate: `clk_div_end`=3, ack on the request's second cycle with data 0xBBBB_AAAA → `sample_valid` every 4 cycles, sample sequence 0xAAAA then 0xBBBB, no `underrun`.
- Clamp: `clk_div_end`=0 → tick period is 3 cycles (MIN_DIV+1).
- Speed change: `clk_div_end`=100; when `div_cnt`=50, drop it to 20 → tick on the next cycle, then a 21-cycle period.
- Underrun: `clk_div_end`=3, `word_ack` withheld → `underrun` pulses every 4 cycles, `sample_out` stays 0. Then ack 0x2222_1111 → next ticks emit 0x1111 and 0x2222.
- Prefetch and concurrency:
  - Words W0 and W1 acked → `word_req` stays low until W0 is fully consumed.
  - Ack coincident with the tick that empties `cur` → the new word is emitted on the next tick.
- Reset and spurious ack: assert `reset_n`=0 while `word_req`=1 → `word_req`=0 immediately, all outputs 0. A `word_ack` pulse while `word_req`=0 → no state change.
